stall_controller: RTL and testbench
===================================

STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles of the multiply unit after a mult/multu leaves E.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles of the multiply unit after a div/divu leaves E.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 D_rs, D_rt  input  5 each  source register numbers of the instruction in D.
REQ-006 D_Tuse_rs, D_Tuse_rt  input  2 each  cycles from D until the operand is consumed; 3 = operand unused.
REQ-007 D_A3  input  5  destination register of the D instruction; 0 = no GRF write.
REQ-008 D_Tnew  input  2  original Tnew of the D instruction from the Tnew decoder: 1 for non-loads, 2 for loads.
REQ-009 D_md_start  input  2  00 none, 01 mult-class, 10 div-class, 11 reserved and treated as 00.
REQ-010 D_md_use  input  1  D instruction reads or writes HI/LO or starts the multiply unit.
REQ-011 stall  output  1  freeze PC and the D register, and insert a bubble into E.
REQ-012 E_A3, M_A3  output  5 each  tracked destination registers, used by the forwarding logic.
REQ-013 E_Tnew, M_Tnew  output  2 each  remaining Tnew at E and at M.
REQ-014 md_busy  output  1  multiply unit occupied.

Function
REQ-015 Scoreboard is two stages, E and M; each holds {A3, Tnew}.
REQ-016 On each edge, E loads {D_A3, D_Tnew} when stall=0; otherwise E loads the bubble {0, 0}.
REQ-017 On each edge, M loads {E_A3, max(E_Tnew-1, 0)}; the decrement saturates at 0.
REQ-018 The W stage is not tracked; its Tnew is always 0.
REQ-019 A register hazard on rs exists when all of the following hold: D_Tuse_rs != 3; D_rs != 0; for stage X in {E, M}, X_A3 == D_rs and D_Tuse_rs < X_Tnew.
REQ-020 A hazard on rt is defined identically using D_rt and D_Tuse_rt.
REQ-021 A3 == 0 never produces a hazard.
REQ-022 The E-stage match takes priority for evaluation purposes only; stall is the OR of all hazard terms.
REQ-023 An md hazard exists when D_md_use=1 and either md_busy=1 or the E stage holds an md-start instruction (e_md_start != 00).
REQ-024 stall = register hazard OR md hazard; stall is purely combinational from current state and D inputs, with zero latency.
REQ-025 Internal e_md_start loads the D_md_start code when stall=0, and loads 00 when stall=1.
REQ-026 Busy counter is 4 bits (it holds values up to DIV_CYCLES).
REQ-027 When e_md_start=01, the counter loads MULT_CYCLES on the edge on which that instruction leaves E.
REQ-028 When e_md_start=10, the counter loads DIV_CYCLES on that edge.
REQ-029 Otherwise the counter decrements if nonzero and holds at 0.
REQ-030 md_busy = (counter != 0).
REQ-031 A counter reload while the counter is nonzero cannot occur, because REQ-023 stalls any md-start in D; the bench asserts this as a property.
REQ-032 A stalled D instruction re-evaluates every cycle; stall deasserts in the cycle the hazard clears, with no extra delay cycle.

Reset
REQ-033 Assertion of reset SHALL asynchronously set E_A3, M_A3, E_Tnew, M_Tnew, e_md_start and the counter to 0.
REQ-034 Consequently stall=0 and md_busy=0 while reset is asserted, regardless of D inputs.
REQ-035 Reset asserted mid-operation (for example during a div) aborts the busy count; the first cycle after release has md_busy=0.

Structure
REQ-036 The shared package / macros file holds Tuse-unused (2'b11), the md_start encodings, the bubble constant, and MULT_CYCLES/DIV_CYCLES defaults.
REQ-037 One sub-module, md_busy_counter, holds the e_md_start register and the busy counter; scoreboard and hazard compare stay in stall_controller.
REQ-038 The existing TnewOriginalDecoder drives D_Tnew externally; it is not instantiated inside this block.

Verification
REQ-039 Load-use: lw $t0 in E (E_A3=8, E_Tnew=2), D add with D_rs=8 and Tuse_rs=1 -> stall=1 for one cycle; the next cycle has M_Tnew=1 and stall=0.
REQ-040 ALU-use: E_A3=8, E_Tnew=1, D_rs=8, Tuse_rs=1 -> stall=0; with Tuse_rs=0 (branch) -> stall=1 for one cycle, then 0.
REQ-041 $zero and unused operand: E_A3=0 matched by D_rs=0 -> stall=0; D_rt=8 with Tuse_rt=3 against E_A3=8, E_Tnew=2 -> stall=0.
REQ-042 Divide: div passes E -> md_busy=1 for exactly 10 cycles; mfhi in D -> stall=1 for 11 cycles (E cycle plus 10), then stall=0.
REQ-043 Back-to-back: mult in E and mult in D -> stall=1, and the second mult issues only after md_busy falls; assert the counter is never reloaded while nonzero.
REQ-044 Reset mid-div: assert reset at counter=6 -> md_busy=0 and stall=0 immediately; all tracked outputs read 0 after release.

Source files
------------

// File: rtl/stall_controller_pkg.sv
// stall_controller_pkg
//   Shared constants and helpers for the pipeline stall controller:
//   - Tuse encoding for "operand not consumed"
//   - multiply/divide start encodings
//   - scoreboard entry type and the bubble entry loaded on a stall
//   - default busy lengths of the multiply unit
package stall_controller_pkg;

  localparam logic [1:0] TUSE_UNUSED = 2'b11;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_RSVD = 2'b11;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int BUSY_CNT_W      = 4;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{a3: 5'd0, tnew: 2'd0};

  // True when a source operand read at Tuse cannot be satisfied by
  // forwarding from the given stage yet. $zero never matches.
  function automatic logic reg_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input sb_entry_t  stage);
    return (tuse != TUSE_UNUSED) && (src != 5'd0) &&
           (stage.a3 == src) && (tuse < stage.tnew);
  endfunction

  // Tnew one stage later, saturating at zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

  // The reserved start code behaves as "no start".
  function automatic logic [1:0] md_norm(input logic [1:0] code);
    return (code == MD_RSVD) ? MD_NONE : code;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter
//   Tracks the multiply/divide start code of the instruction in E and the
//   remaining busy cycles of the multiply unit once that instruction has
//   left E.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   stall        current stall; a stalled D instruction does not enter E
//   d_md_start   start code of the D instruction
//   e_md_start   start code of the instruction now in E
//   md_busy      multiply unit occupied (counter nonzero)
module md_busy_counter
  import stall_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [1:0] d_md_start,
  output logic [1:0] e_md_start,
  output logic       md_busy
);

  logic [BUSY_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_md_start <= MD_NONE;
    end else if (stall) begin
      e_md_start <= MD_NONE;
    end else begin
      e_md_start <= md_norm(d_md_start);
    end
  end

  // The E instruction always leaves E on the next edge, so the busy length
  // is loaded directly from the E start code. A reload while still busy is
  // prevented upstream: any md-start in D stalls while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (e_md_start == MD_MULT) begin
      count <= BUSY_CNT_W'(MULT_CYCLES);
    end else if (e_md_start == MD_DIV) begin
      count <= BUSY_CNT_W'(DIV_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign md_busy = (count != '0);

endmodule

// File: rtl/stall_controller.sv
// stall_controller
//   Decode-stage stall generation. Keeps a two-entry {A3, Tnew} scoreboard
//   for the E and M stages, compares the D operands against it, and adds a
//   structural hazard for the multiply unit.
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   D_rs, D_rt              source registers of the D instruction
//   D_Tuse_rs, D_Tuse_rt    cycles until each operand is consumed (3 = unused)
//   D_A3, D_Tnew            destination and original Tnew of the D instruction
//   D_md_start, D_md_use    multiply unit start code / HI-LO usage in D
//   stall                   freeze PC and D, bubble into E
//   E_A3, E_Tnew            scoreboard entry at E
//   M_A3, M_Tnew            scoreboard entry at M
//   md_busy                 multiply unit occupied
module stall_controller
  import stall_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_md_start,
  input  logic       D_md_use,
  output logic       stall,
  output logic [4:0] E_A3,
  output logic [4:0] M_A3,
  output logic [1:0] E_Tnew,
  output logic [1:0] M_Tnew,
  output logic       md_busy
);

  sb_entry_t  e_q;
  sb_entry_t  m_q;
  logic [1:0] e_md_start;
  logic       hazard_rs;
  logic       hazard_rt;
  logic       hazard_md;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= SB_BUBBLE;
      m_q <= SB_BUBBLE;
    end else begin
      e_q <= stall ? SB_BUBBLE : sb_entry_t'{a3: D_A3, tnew: D_Tnew};
      m_q <= sb_entry_t'{a3: e_q.a3, tnew: tnew_dec(e_q.tnew)};
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .d_md_start (D_md_start),
    .e_md_start (e_md_start),
    .md_busy    (md_busy)
  );

  // E holds the newer producer, but any unsatisfied match stalls, so the
  // two stage terms are simply ORed.
  always_comb begin
    hazard_rs = reg_hazard(D_rs, D_Tuse_rs, e_q) ||
                reg_hazard(D_rs, D_Tuse_rs, m_q);
    hazard_rt = reg_hazard(D_rt, D_Tuse_rt, e_q) ||
                reg_hazard(D_rt, D_Tuse_rt, m_q);
    hazard_md = D_md_use && (md_busy || (e_md_start != MD_NONE));
    stall     = hazard_rs || hazard_rt || hazard_md;
  end

  assign E_A3   = e_q.a3;
  assign E_Tnew = e_q.tnew;
  assign M_A3   = m_q.a3;
  assign M_Tnew = m_q.tnew;

endmodule

// File: tb/tb_stall_controller.sv
module tb_stall_controller;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_start;
  logic       D_md_use;
  logic       stall, md_busy;
  logic [4:0] E_A3, M_A3;
  logic [1:0] E_Tnew, M_Tnew;

  int n_checks = 0;
  int n_fail   = 0;

  stall_controller dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_A3       (D_A3),
    .D_Tnew     (D_Tnew),
    .D_md_start (D_md_start),
    .D_md_use   (D_md_use),
    .stall      (stall),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Before each edge: the multiply unit must never be reloaded while busy.
  task automatic tick();
    if (!reset) begin
      n_checks++;
      assert (!((dut.u_md.e_md_start != 2'b00) && (dut.u_md.count != 4'd0))) else begin
        n_fail++;
        $error("FAIL reload_while_busy observed=%0d expected=0", dut.u_md.count);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic [1:0] mds, input logic mdu);
    D_rs = rs; D_Tuse_rs = tu_rs; D_rt = rt; D_Tuse_rt = tu_rt;
    D_A3 = a3; D_Tnew = tn; D_md_start = mds; D_md_use = mdu;
    #1;
  endtask

  task automatic set_nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, 2'b00, 1'b0);
  endtask

  initial begin
    // Reset with hazard-looking D inputs.
    reset = 1'b1;
    set_d(5'd8, 2'd0, 5'd8, 2'd0, 5'd8, 2'd2, 2'b10, 1'b1);
    #2;
    chk("rst_stall",  stall,   0);
    chk("rst_busy",   md_busy, 0);
    chk("rst_E_A3",   E_A3,    0);
    chk("rst_E_Tnew", E_Tnew,  0);
    chk("rst_M_A3",   M_A3,    0);
    chk("rst_M_Tnew", M_Tnew,  0);
    tick();
    chk("rst_edge_E_A3", E_A3,    0);
    chk("rst_edge_busy", md_busy, 0);
    reset = 1'b0;

    // Load-use: lw $8 then add using $8 at Tuse 1.
    set_d(5'd9, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 2'b00, 1'b0);
    chk("lw_issue_stall", stall, 0);
    tick();
    chk("lw_E_A3",   E_A3,   8);
    chk("lw_E_Tnew", E_Tnew, 2);
    set_d(5'd8, 2'd1, 5'd10, 2'd1, 5'd11, 2'd1, 2'b00, 1'b0);
    chk("loaduse_stall", stall, 1);
    tick();
    chk("loaduse_bubble_E_A3", E_A3,   0);
    chk("loaduse_M_A3",        M_A3,   8);
    chk("loaduse_M_Tnew",      M_Tnew, 1);
    chk("loaduse_release",     stall,  0);
    tick();
    chk("add_E_A3",   E_A3,   11);
    chk("add_E_Tnew", E_Tnew, 1);

    // ALU-use: $11 produced with Tnew 1.
    set_d(5'd11, 2'd1, 5'd0, 2'd3, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("alu_tuse1_stall", stall, 0);
    set_d(5'd11, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("alu_branch_stall", stall, 1);
    tick();
    chk("alu_M_A3",      M_A3,   11);
    chk("alu_M_Tnew",    M_Tnew, 0);
    chk("alu_branch_go", stall,  0);
    tick();

    // $zero and unused operands.
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd2, 2'b00, 1'b0);
    chk("zero_reg_stall", stall, 0);
    tick();
    set_d(5'd0, 2'd3, 5'd8, 2'd3, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("unused_rt_stall", stall, 0);
    set_d(5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("rt_E_stall", stall, 1);
    set_nop();
    tick();
    set_d(5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("rt_M_tuse0_stall", stall, 1);
    set_d(5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd1, 2'b00, 1'b0);
    chk("rt_M_tuse1_stall", stall, 0);
    set_nop();
    tick();
    tick();

    // Divide followed by mfhi.
    set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd1, 2'b10, 1'b1);
    chk("div_issue_stall", stall,   0);
    chk("div_issue_busy",  md_busy, 0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1, 2'b00, 1'b1);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("div_stall_%0d", i), stall, 1);
      chk($sformatf("div_busy_%0d", i), md_busy, (i > 0) ? 8'd1 : 8'd0);
      tick();
    end
    chk("div_done_stall", stall,   0);
    chk("div_done_busy",  md_busy, 0);
    tick();
    chk("mfhi_E_A3", E_A3, 12);

    // Back-to-back mult.
    set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd1, 2'b01, 1'b1);
    chk("mult1_stall", stall, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mult2_stall_%0d", i), stall, 1);
      chk($sformatf("mult2_busy_%0d", i), md_busy, (i > 0) ? 8'd1 : 8'd0);
      tick();
    end
    chk("mult2_go", stall, 0);
    tick();
    chk("mult2_in_E_busy", md_busy, 0);
    set_nop();
    tick();
    chk("mult2_busy", md_busy, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mult2_drained", md_busy, 0);

    // Reset in the middle of a divide.
    set_d(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd1, 2'b10, 1'b1);
    chk("div2_issue_stall", stall, 0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("div2_busy",   md_busy, 1);
    chk("div2_E_A3",   E_A3,    5);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1, 2'b00, 1'b1);
    chk("div2_mfhi_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("midrst_stall",  stall,   0);
    chk("midrst_busy",   md_busy, 0);
    chk("midrst_E_A3",   E_A3,    0);
    chk("midrst_E_Tnew", E_Tnew,  0);
    chk("midrst_M_A3",   M_A3,    0);
    chk("midrst_M_Tnew", M_Tnew,  0);
    #2;
    reset = 1'b0;
    #1;
    chk("postrst_busy",  md_busy, 0);
    chk("postrst_stall", stall,   0);
    chk("postrst_M_A3",  M_A3,    0);
    tick();
    chk("postrst_edge_busy", md_busy, 0);
    chk("postrst_mfhi_E_A3", E_A3,    12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
